dsc_epoch_sched: RTL and testbench

//  Round-robin scheduler that time-shares one two-operand DSC stochastic datapath (shared counter + comparators
//  + AND/OR gate) between NUM_REQ requesters. Per granted request it clears the SNG counter, runs one full
//  2^WIDTH-cycle unary epoch, counts ones on the combined stream and returns the binary result with a tag.

---
 rtl/dsc_epoch_sched.sv | 209 ++++++++++++++++++++
 tb/tb_dsc_epoch_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_epoch_sched.sv
// ---------------------------------------------------------------------------
// dsc_epoch_sched
//
// Round-robin scheduler that time-shares one two-operand stochastic (DSC)
// datapath between NUM_REQ requesters. For each granted request it clears the
// shared SNG counter, runs one full 2^WIDTH-cycle unary epoch, counts the ones
// of the combined stream (AND for OP=0, OR for OP=1) and returns the count
// together with the id of the requester that owns it.
//
// Parameters
//   WIDTH    operand/result width; epoch length is 2^WIDTH cycles
//   NUM_REQ  number of requesters (>= 2)
//   OP       0: AND the two streams (min), 1: OR the two streams (max)
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester request valid            [NUM_REQ]
//   req_ready     per-requester accept, one-hot or zero  [NUM_REQ]
//   req_a, req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   sng_clr       counter clear to the shared SNG
//   sng_en        counter enable to the shared SNG
//   sng_bin_a/b   operands latched at grant, drive the SNG comparators
//   sn_a, sn_b    stream bits returned by the SNG
//   sng_overflow  SNG counter overflow
//   res_valid/res_ready/res_data/res_id   result handshake
//   busy          high in every state except IDLE
//
// Build option
//   DSC_SCHED_OVF_CHECK_EN : adds output ovf_err, a sticky flag raised when
//   sng_overflow is high in any RUN cycle but the last, or low in the last RUN
//   cycle. Cleared only by rst. Without the macro sng_overflow is ignored.
// ---------------------------------------------------------------------------
module dsc_epoch_sched #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int OP      = 0,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     sng_clr,
  output logic                     sng_en,
  output logic [WIDTH-1:0]         sng_bin_a,
  output logic [WIDTH-1:0]         sng_bin_b,
  input  logic                     sn_a,
  input  logic                     sn_b,
  input  logic                     sng_overflow,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [IDW-1:0]           res_id,
  output logic                     busy
`ifdef DSC_SCHED_OVF_CHECK_EN
  ,
  output logic                     ovf_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] EP_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] EP_ONE  = WIDTH'(1);
  localparam logic [IDW-1:0]   ID_LAST = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0]   ID_ONE  = IDW'(1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] ep_cnt;

  // One epoch never produces more than 2^WIDTH-1 ones (the comparators are
  // strict), so the accumulator cannot wrap and needs no saturation.
  function automatic logic [WIDTH-1:0] acc_step(input logic [WIDTH-1:0] cur,
                                                input logic             bit_in);
    acc_step = cur + WIDTH'(bit_in);
  endfunction

  // Requester operand lanes unpacked for indexed selection.
  logic [WIDTH-1:0] a_lane [NUM_REQ];
  logic [WIDTH-1:0] b_lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*WIDTH +: WIDTH];
    assign b_lane[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Combined stream bit from the two SNG comparators.
  logic comb_bit;
  assign comb_bit = (OP != 0) ? (sn_a | sn_b) : (sn_a & sn_b);

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  int               cand_int;
  logic [IDW-1:0]   cand;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int = int'(rr_ptr) + k;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand = IDW'(cand_int);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    // Accept is only offered while idle; the datapath is single-occupancy.
    if ((state == IDLE) && grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = grant_oh;

`ifdef DSC_SCHED_OVF_CHECK_EN
  // The SNG counter must overflow exactly on the last epoch cycle.
  logic ovf_bad;
  assign ovf_bad = (ep_cnt == EP_LAST) ? !sng_overflow : sng_overflow;
`else
  logic unused_ovf;
  assign unused_ovf = sng_overflow;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      acc       <= '0;
      ep_cnt    <= '0;
      sng_clr   <= 1'b0;
      sng_en    <= 1'b0;
      sng_bin_a <= '0;
      sng_bin_b <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
`ifdef DSC_SCHED_OVF_CHECK_EN
      ovf_err   <= 1'b0;
`endif
    end else begin
      case (state)
        // Grant stage: capture operands and owner, advance the pointer.
        IDLE: begin
          if (grant_any) begin
            sng_bin_a <= a_lane[grant_idx];
            sng_bin_b <= b_lane[grant_idx];
            res_id    <= grant_idx;
            rr_ptr    <= (grant_idx == ID_LAST) ? '0 : grant_idx + ID_ONE;
            sng_clr   <= 1'b1;
            busy      <= 1'b1;
            state     <= CLR;
          end
        end

        // Clear stage: SNG counter cleared this cycle, epoch starts next.
        CLR: begin
          acc     <= '0;
          ep_cnt  <= '0;
          sng_clr <= 1'b0;
          sng_en  <= 1'b1;
          state   <= RUN;
        end

        // Epoch stage: 2^WIDTH cycles; the last cycle's bit is still counted.
        RUN: begin
          acc    <= acc_step(acc, comb_bit);
          ep_cnt <= ep_cnt + EP_ONE;
`ifdef DSC_SCHED_OVF_CHECK_EN
          if (ovf_bad) ovf_err <= 1'b1;
`endif
          if (ep_cnt == EP_LAST) begin
            res_data  <= acc_step(acc, comb_bit);
            res_valid <= 1'b1;
            sng_en    <= 1'b0;
            state     <= DONE;
          end
        end

        // Result stage: hold until the consumer accepts.
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_epoch_sched.sv
// ---------------------------------------------------------------------------
// tb_dsc_epoch_sched
//
// Two schedulers (OP=0 and OP=1) run lock-step on the same requests, each
// driving its own model of the shared SNG counter. Expected results are the
// minimum (AND) and maximum (OR) of the granted operands; grant order follows
// a round-robin pointer kept in the bench.
// ---------------------------------------------------------------------------
module tb_dsc_epoch_sched;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_ready;
  logic                     ovf_force;

  logic [NUM_REQ-1:0] req_ready0, req_ready1;
  logic               sng_clr0, sng_clr1, sng_en0, sng_en1;
  logic [WIDTH-1:0]   sng_bin_a0, sng_bin_a1, sng_bin_b0, sng_bin_b1;
  logic               sn_a0, sn_a1, sn_b0, sn_b1, ovf0, ovf1;
  logic               res_valid0, res_valid1, busy0, busy1;
  logic [WIDTH-1:0]   res_data0, res_data1;
  logic [IDW-1:0]     res_id0, res_id1;
`ifdef DSC_SCHED_OVF_CHECK_EN
  logic               ovf_err0, ovf_err1;
`endif

  dsc_epoch_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .OP(0)) u_and (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_a(req_a), .req_b(req_b), .sng_clr(sng_clr0), .sng_en(sng_en0),
    .sng_bin_a(sng_bin_a0), .sng_bin_b(sng_bin_b0), .sn_a(sn_a0), .sn_b(sn_b0),
    .sng_overflow(ovf0), .res_valid(res_valid0), .res_ready(res_ready),
    .res_data(res_data0), .res_id(res_id0), .busy(busy0)
`ifdef DSC_SCHED_OVF_CHECK_EN
    , .ovf_err(ovf_err0)
`endif
  );

  dsc_epoch_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .OP(1)) u_or (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .sng_clr(sng_clr1), .sng_en(sng_en1),
    .sng_bin_a(sng_bin_a1), .sng_bin_b(sng_bin_b1), .sn_a(sn_a1), .sn_b(sn_b1),
    .sng_overflow(ovf1), .res_valid(res_valid1), .res_ready(res_ready),
    .res_data(res_data1), .res_id(res_id1), .busy(busy1)
`ifdef DSC_SCHED_OVF_CHECK_EN
    , .ovf_err(ovf_err1)
`endif
  );

  // Shared-SNG models: up-counter with clear/enable, strict comparators.
  logic [WIDTH-1:0] cnt0, cnt1;
  always_ff @(posedge clk) begin
    if (rst || sng_clr0) cnt0 <= '0;
    else if (sng_en0)    cnt0 <= cnt0 + 4'd1;
    if (rst || sng_clr1) cnt1 <= '0;
    else if (sng_en1)    cnt1 <= cnt1 + 4'd1;
  end
  assign sn_a0 = sng_bin_a0 > cnt0;
  assign sn_b0 = sng_bin_b0 > cnt0;
  assign sn_a1 = sng_bin_a1 > cnt1;
  assign sn_b1 = sng_bin_b1 > cnt1;
  assign ovf0  = (sng_en0 && (cnt0 == 4'hF)) || ovf_force;
  assign ovf1  = (sng_en1 && (cnt1 == 4'hF)) || ovf_force;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    ovf_force = 1'b0;
    step();
    step();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return 0;
  endfunction

  function automatic logic [3:0] lane(input logic [15:0] v, input int i);
    return v[i*4 +: 4];
  endfunction

  // One full transaction: grant, epoch, optional result stall, handshake.
  task automatic run_txn(input logic [3:0] mask, input logic [15:0] av,
                         input logic [15:0] bv, input int delay, input int ovf_at,
                         input int exp_g, input logic [3:0] exp_and,
                         input logic [3:0] exp_or);
    int n, en_cnt, rr_bad, stable_bad;
    logic [3:0] d0, d1, oh;
    logic [1:0] id0;
    oh = 4'b0001 << exp_g;
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    res_ready = (delay == 0);
    ovf_force = 1'b0;
    #1;
    check("grant_and", req_ready0, oh);
    check("grant_or", req_ready1, oh);
    check("idle_busy", busy0, 0);
    step();
    check("clr_phase", {sng_clr0, sng_en0, busy0}, 3'b101);
    n = 1; en_cnt = 0; rr_bad = 0;
    while (!res_valid0 && n < 40) begin
      if (sng_en0) en_cnt++;
      if ((req_ready0 != 0) || (req_ready1 != 0)) rr_bad++;
      ovf_force = (ovf_at >= 0) && (n == ovf_at + 2);
      step();
      n++;
    end
    ovf_force = 1'b0;
    check("latency", n, 18);
    check("en_cycles", en_cnt, 16);
    check("no_grant_busy", rr_bad, 0);
    check("res_and", res_data0, exp_and);
    check("res_or", res_data1, exp_or);
    check("res_id_and", res_id0, exp_g);
    check("res_id_or", res_id1, exp_g);
    d0 = res_data0; d1 = res_data1; id0 = res_id0; stable_bad = 0;
    for (int i = 0; i < delay; i++) begin
      if (!res_valid0 || !res_valid1 || res_data0 !== d0 || res_data1 !== d1 ||
          res_id0 !== id0 || req_ready0 != 0 || req_ready1 != 0 || sng_en0)
        stable_bad++;
      step();
    end
    if (delay > 0) check("stall_stable", stable_bad, 0);
    res_ready = 1'b1;
    req_valid = '0;
    #1;
    check("valid_at_hs", {res_valid0, res_valid1}, 2'b11);
    step();
    check("back_idle", {res_valid0, res_valid1, busy0, busy1}, 0);
    check("bin_a_hold", sng_bin_a0, lane(av, exp_g));
    check("bin_b_hold", sng_bin_b1, lane(bv, exp_g));
    ptr_m = (exp_g + 1) % NUM_REQ;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] av;
    logic [15:0] bv;
    int          delay;
    int          exp_g;
    logic [3:0]  exp_and;
    logic [3:0]  exp_or;
  } vec_t;

  vec_t vecs [7];
  int   rr_exp [5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0]  m, ea, eo, xa, xb;
    logic [15:0] av, bv;
    int          g;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    ovf_force = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    check("rst_ready", req_ready0, 0);
    check("rst_ctrl", {sng_clr0, sng_en0, res_valid0, busy0}, 0);
    check("rst_bins", {sng_bin_a0, sng_bin_b0}, 0);
    check("rst_res", {res_data0, res_id0}, 0);

    // Pointer starts at 0; expectations follow from it and each grant.
    vecs[0] = '{4'b0001, 16'h0005, 16'h0009, 0, 0, 4'd5,  4'd9};
    vecs[1] = '{4'b0100, 16'h0300, 16'h0C00, 0, 2, 4'd3,  4'd12};
    vecs[2] = '{4'b0010, 16'hA90B, 16'h5604, 0, 1, 4'd0,  4'd0};
    vecs[3] = '{4'b1000, 16'hF000, 16'hF000, 0, 3, 4'd15, 4'd15};
    vecs[4] = '{4'b1010, 16'h2070, 16'h30A0, 5, 1, 4'd7,  4'd10};
    vecs[5] = '{4'b0011, 16'h004F, 16'h0040, 0, 0, 4'd0,  4'd15};
    vecs[6] = '{4'b0001, 16'h0001, 16'h0001, 2, 0, 4'd1,  4'd1};
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].mask, vecs[i].av, vecs[i].bv, vecs[i].delay, -1,
              vecs[i].exp_g, vecs[i].exp_and, vecs[i].exp_or);

    // Randomized requests against the bench round-robin and min/max model.
    for (int i = 0; i < 24; i++) begin
      m  = 4'($urandom_range(1, 15));
      av = 16'($urandom);
      bv = 16'($urandom);
      g  = pick(m, ptr_m);
      xa = lane(av, g); xb = lane(bv, g);
      ea = (xa < xb) ? xa : xb;
      eo = (xa < xb) ? xb : xa;
      run_txn(m, av, bv, int'($urandom_range(0, 3)), -1, g, ea, eo);
    end

    // All requesters held: strict rotation from 0 after reset.
    do_reset();
    rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 3; rr_exp[4] = 0;
    for (int i = 0; i < 5; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      xa = lane(av, rr_exp[i]); xb = lane(bv, rr_exp[i]);
      ea = (xa < xb) ? xa : xb;
      eo = (xa < xb) ? xb : xa;
      run_txn(4'hF, av, bv, 0, -1, rr_exp[i], ea, eo);
    end

    // Reset during RUN cycle 7 discards the epoch and rewinds the pointer.
    req_valid = 4'b0010; req_a = 16'h00F0; req_b = 16'h00F0;
    #1;
    check("mid_grant", req_ready0, 4'b0010);
    step();
    req_valid = '0;
    for (int i = 0; i < 8; i++) step();
    check("mid_run_en", sng_en0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ctrl", {sng_en0, res_valid0, busy0, sng_en1, res_valid1}, 0);
    for (int i = 0; i < 20; i++) step();
    check("mid_rst_no_result", {res_valid0, res_valid1}, 0);
    ptr_m = 0;
    run_txn(4'hF, 16'h1234, 16'h4321, 0, -1, 0, 4'd1, 4'd4);

`ifdef DSC_SCHED_OVF_CHECK_EN
    check("ovf_clean", {ovf_err0, ovf_err1}, 0);
    run_txn(4'b0100, 16'h0900, 16'h0600, 0, 3, 2, 4'd6, 4'd9);
    check("ovf_set", {ovf_err0, ovf_err1}, 2'b11);
    run_txn(4'b0001, 16'h0003, 16'h0002, 0, -1, 0, 4'd2, 4'd3);
    check("ovf_sticky", {ovf_err0, ovf_err1}, 2'b11);
    do_reset();
    check("ovf_rst", {ovf_err0, ovf_err1}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
